// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-bit register pointer and a single-cycle register-file port.
// Define I2C_SLV_FILTER_EN to add a FILT_LEN-cycle stable filter on SCL/SDA after synchronization.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    generate
        if (FILT_LEN < 1) begin : g_bad_filt_len
            $error("FILT_LEN must be at least 1");
        end
    endgenerate

    // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f;
    logic       scl_p, sda_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLV_FILTER_EN
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic [CW-1:0] scl_cnt, sda_cnt;

    // Output follows the input only after FILT_LEN consecutive samples of the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILT_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILT_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_f & ~scl_p;
    assign scl_fall   = ~scl_f & scl_p;
    assign start_cond = ~sda_f & sda_p & scl_f & scl_p;
    assign stop_cond  = sda_f & ~sda_p & scl_f & scl_p;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic       rw, rw_n;
    logic       ack_on, ack_on_n;     // ACK slot: SDA already pulled low for the 9th clock
    logic       rd_first, rd_first_n; // next scl_fall fetches a new read byte
    logic       ld_pend, ld_pend_n;   // rd_data is valid this cycle
    logic       sda_oe_n, wr_en_n, rd_req_n, busy_n, start_det_n, stop_det_n;
    logic [7:0] reg_addr_n, wr_data_n;
    logic [7:0] byte_in;

    assign byte_in = {shift[6:0], sda_f};

    // NOTE: every next-value gets a default first so always_comb can never infer a latch.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shift_n     = shift;
        rw_n        = rw;
        ack_on_n    = ack_on;
        rd_first_n  = rd_first;
        ld_pend_n   = 1'b0;
        sda_oe_n    = sda_oe;
        reg_addr_n  = reg_addr;
        wr_en_n     = 1'b0;
        wr_data_n   = wr_data;
        rd_req_n    = 1'b0;
        busy_n      = busy;
        start_det_n = 1'b0;
        stop_det_n  = 1'b0;

        if (start_cond) begin
            state_n     = S_ADDR;
            cnt_n       = 3'd0;
            sda_oe_n    = 1'b0;
            ack_on_n    = 1'b0;
            rd_first_n  = 1'b0;
            start_det_n = 1'b1;
        end else if (stop_cond) begin
            state_n    = S_IDLE;
            sda_oe_n   = 1'b0;
            busy_n     = 1'b0;
            ack_on_n   = 1'b0;
            rd_first_n = 1'b0;
            stop_det_n = 1'b1;
        end else begin
            if (ld_pend) begin
                shift_n = rd_data;
                if (state == S_RDATA) sda_oe_n = ~rd_data[7];
            end
            case (state)
                S_ADDR: if (scl_rise) begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (shift[6:0] == DEV_ADDR) begin
                            state_n  = S_ADDR_ACK;
                            busy_n   = 1'b1;
                            rw_n     = sda_f;
                            ack_on_n = 1'b0;
                        end else begin
                            state_n = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!ack_on) begin
                        sda_oe_n = 1'b1;
                        ack_on_n = 1'b1;
                        rd_req_n = rw;
                        ld_pend_n = rw;
                    end else begin
                        ack_on_n = 1'b0;
                        cnt_n    = 3'd0;
                        if (rw) begin
                            state_n  = S_RDATA;
                            sda_oe_n = ~shift[7];
                        end else begin
                            state_n  = S_SUB;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                S_SUB, S_WDATA: if (scl_rise) begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        ack_on_n = 1'b0;
                        if (state == S_SUB) begin
                            reg_addr_n = byte_in;
                            state_n    = S_SUB_ACK;
                        end else begin
                            wr_data_n = byte_in;
                            wr_en_n   = 1'b1;
                            state_n   = S_WDATA_ACK;
                        end
                    end
                end
                S_SUB_ACK, S_WDATA_ACK: if (scl_fall) begin
                    if (!ack_on) begin
                        sda_oe_n = 1'b1;
                        ack_on_n = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        ack_on_n = 1'b0;
                        cnt_n    = 3'd0;
                        state_n  = S_WDATA;
                        if (state == S_WDATA_ACK) reg_addr_n = reg_addr + 8'd1;
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (rd_first) begin
                            rd_first_n = 1'b0;
                            rd_req_n   = 1'b1;
                            ld_pend_n  = 1'b1;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) state_n = S_RACK;
                    end
                end
                S_RACK: begin
                    if (scl_fall) sda_oe_n = 1'b0;
                    if (scl_rise) begin
                        if (!sda_f) begin
                            reg_addr_n = reg_addr + 8'd1;
                            rd_first_n = 1'b1;
                            cnt_n      = 3'd0;
                            state_n    = S_RDATA;
                        end else begin
                            state_n = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: sda_oe_n = 1'b0;
                default:  state_n = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            rd_first  <= 1'b0;
            ld_pend   <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            wr_en     <= 1'b0;
            wr_data   <= 8'h00;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift     <= shift_n;
            rw        <= rw_n;
            ack_on    <= ack_on_n;
            rd_first  <= rd_first_n;
            ld_pend   <= ld_pend_n;
            sda_oe    <= sda_oe_n;
            reg_addr  <= reg_addr_n;
            wr_en     <= wr_en_n;
            wr_data   <= wr_data_n;
            rd_req    <= rd_req_n;
            busy      <= busy_n;
            start_det <= start_det_n;
            stop_det  <= stop_det_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master, register-file model and transaction-level reference.
module tb_i2c_slave_regs;

    localparam logic [6:0] DEV = 7'h4B;
    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_en, rd_req, busy, start_det, stop_det;
    logic [7:0] reg_addr, wr_data;
    logic [7:0] rd_data = 8'h00;

    always #5 clk = ~clk;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regs #(.DEV_ADDR(DEV), .FILT_LEN(3)) dut (
        .clk(clk), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(rd_data), .busy(busy),
        .start_det(start_det), .stop_det(stop_det)
    );

    // Register file seen by the DUT, and the reference model's own view.
    logic [7:0]  rf_mem  [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_ptr = 8'h00;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int start_cnt, stop_cnt, oe_cnt, busy_cnt;
    int n_checks = 0, n_fail = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                wr_q.push_back({reg_addr, wr_data});
                rf_mem[reg_addr] = wr_data;
            end
            if (rd_req) begin
                rd_q.push_back(reg_addr);
                rd_data = rf_mem[reg_addr];
            end
            if (start_det) start_cnt++;
            if (stop_det)  stop_cnt++;
            if (sda_oe)    oe_cnt++;
            if (busy)      busy_cnt++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        start_cnt = 0; stop_cnt = 0; oe_cnt = 0; busy_cnt = 0;
    endtask

    // One SCL period; line is the bus level sampled mid-way through SCL high.
    task automatic bit_out(input logic b, input logic glitch, output logic line);
        sda_m = b;
        wait_clks(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clks(4); scl_m = 1'b0; wait_clks(2); scl_m = 1'b1; wait_clks(Q);
        end else begin
            wait_clks(Q);
        end
        line = sda_line;
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b0; wait_clks(Q); scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic rstart_cond();
        sda_m = 1'b1; wait_clks(Q); scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q); scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; wait_clks(Q); scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic line;
        for (int i = 7; i >= 0; i--) bit_out(b[i], i == glitch_bit, line);
        bit_out(1'b1, 1'b0, line);
        ack = ~line;
    endtask

    task automatic recv_byte(input logic ack_it, output logic [7:0] data);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, 1'b0, line);
            data[i] = line;
        end
        bit_out(~ack_it, 1'b0, line);
    endtask

    // Full write transaction checked against the transaction-level model.
    task automatic run_write(input logic [7:0] a, input int n, input logic [31:0] d,
                             output logic [4:0] ack_mask, output int nwr);
        logic        ack, match;
        logic [7:0]  b;
        logic [4:0]  exp_mask;
        logic [15:0] exp_q[$];
        logic [7:0]  ptr0;
        ptr0  = ref_ptr;
        match = (a[7:1] == DEV) && !a[0];
        exp_mask = '0;
        if (match) begin
            exp_mask = 5'((1 << (n + 1)) - 1);
            for (int k = 0; k < n; k++) begin
                b = d[31 - 8 * k -: 8];
                if (k == 0) ref_ptr = b;
                else begin
                    exp_q.push_back({ref_ptr, b});
                    ref_mem[ref_ptr] = b;
                    ref_ptr = ref_ptr + 8'd1;
                end
            end
        end
        clear_mon();
        ack_mask = '0;
        start_cond();
        send_byte(a, -1, ack);
        ack_mask[0] = ack;
        for (int k = 0; k < n; k++) begin
            send_byte(d[31 - 8 * k -: 8], -1, ack);
            ack_mask[k + 1] = ack;
        end
        stop_cond();
        nwr = wr_q.size();
        check("wr_acks", 32'(ack_mask), 32'(exp_mask));
        check("wr_count", 32'(nwr), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
            check("wr_addr_data", 32'(wr_q[k]), 32'(exp_q[k]));
        check("wr_reg_addr", 32'(reg_addr), 32'(ref_ptr));
        check("wr_start_det", 32'(start_cnt), 32'd1);
        check("wr_stop_det", 32'(stop_cnt), 32'd1);
        check("wr_busy_end", 32'(busy), 32'd0);
        check("wr_busy_seen", 32'(busy_cnt != 0), 32'(match));
        check("wr_oe_seen", 32'(oe_cnt != 0), 32'(match));
        if (!match) check("nomatch_ptr_kept", 32'(reg_addr), 32'(ptr0));
    endtask

    // Sub-address write, repeated START, n-byte read with a final NACK.
    task automatic run_read(input logic [7:0] sub, input int n);
        logic       ack;
        logic [7:0] got;
        logic [7:0] exp_addrs[$];
        clear_mon();
        start_cond();
        send_byte({DEV, 1'b0}, -1, ack);
        check("rd_addr_w_ack", 32'(ack), 32'd1);
        send_byte(sub, -1, ack);
        check("rd_sub_ack", 32'(ack), 32'd1);
        ref_ptr = sub;
        rstart_cond();
        send_byte({DEV, 1'b1}, -1, ack);
        check("rd_addr_r_ack", 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            exp_addrs.push_back(ref_ptr);
            recv_byte(k != n - 1, got);
            check("rd_byte", 32'(got), 32'(ref_mem[ref_ptr]));
            if (k != n - 1) ref_ptr = ref_ptr + 8'd1;
        end
        wait_clks(Q);
        check("rd_oe_after_nack", 32'(sda_oe), 32'd0);
        check("rd_busy_before_stop", 32'(busy), 32'd1);
        sda_m = 1'b0; wait_clks(Q); scl_m = 1'b1; wait_clks(Q);
        check("rd_oe_in_stop", 32'(sda_oe), 32'd0);
        sda_m = 1'b1; wait_clks(2 * Q);
        check("rd_req_count", 32'(rd_q.size()), 32'(n));
        for (int k = 0; k < n && k < rd_q.size(); k++)
            check("rd_req_addr", 32'(rd_q[k]), 32'(exp_addrs[k]));
        check("rd_reg_addr", 32'(reg_addr), 32'(ref_ptr));
        check("rd_start_det", 32'(start_cnt), 32'd2);
        check("rd_stop_det", 32'(stop_cnt), 32'd1);
        check("rd_busy_end", 32'(busy), 32'd0);
        check("rd_no_write", 32'(wr_q.size()), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]  a;
        logic [2:0]  n;
        logic [31:0] d;
        logic [4:0]  exp_ack;
        logic [2:0]  exp_wr;
        logic [7:0]  exp_ptr;
    } wvec_t;

    initial begin
        wvec_t      tbl[6];
        logic [4:0] am;
        int         nwr;
        logic       ack, line;
        logic [7:0] gb, exp_byte;
        logic [6:0] a7;

        tbl[0] = '{8'h96, 3'd3, 32'h2EFE0700, 5'b01111, 3'd2, 8'h30};
        tbl[1] = '{8'h74, 3'd2, 32'h55660000, 5'b00000, 3'd0, 8'h30};
        tbl[2] = '{8'h96, 3'd3, 32'hFF112200, 5'b01111, 3'd2, 8'h01};
        tbl[3] = '{8'h96, 3'd1, 32'h80000000, 5'b00011, 3'd0, 8'h80};
        tbl[4] = '{8'h96, 3'd4, 32'h10A1A2A3, 5'b11111, 3'd3, 8'h13};
        tbl[5] = '{8'h4A, 3'd1, 32'h33000000, 5'b00000, 3'd0, 8'h13};

        for (int i = 0; i < 256; i++) begin
            rf_mem[i]  = 8'($urandom);
            ref_mem[i] = rf_mem[i];
        end
        clear_mon();

        wait_clks(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_stop", 32'({start_det, stop_det}), 32'd0);
        reset_n = 1'b1;
        wait_clks(5);

        for (int i = 0; i < 6; i++) begin
            run_write(tbl[i].a, int'(tbl[i].n), tbl[i].d, am, nwr);
            check("tbl_acks", 32'(am), 32'(tbl[i].exp_ack));
            check("tbl_wr_count", 32'(nwr), 32'(tbl[i].exp_wr));
            check("tbl_reg_addr", 32'(reg_addr), 32'(tbl[i].exp_ptr));
        end

        // Read of 2E/2F: ACK first byte, NACK second.
        rf_mem[8'h2E] = 8'hBE; ref_mem[8'h2E] = 8'hBE;
        rf_mem[8'h2F] = 8'hEF; ref_mem[8'h2F] = 8'hEF;
        run_read(8'h2E, 2);
        check("plan_read_ptr", 32'(reg_addr), 32'h2F);

        // STOP after 5 data bits: partial byte dropped, pointer kept.
        clear_mon();
        start_cond();
        send_byte(8'h96, -1, ack);
        send_byte(8'h40, -1, ack);
        gb = 8'hC3;
        for (int i = 7; i >= 3; i--) bit_out(gb[i], 1'b0, line);
        stop_cond();
        ref_ptr = 8'h40;
        check("abort_no_wr", 32'(wr_q.size()), 32'd0);
        check("abort_ptr", 32'(reg_addr), 32'h40);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_stop_det", 32'(stop_cnt), 32'd1);

        // SCL glitch inside a data bit.
        clear_mon();
        gb = 8'hB5;
`ifdef I2C_SLV_FILTER_EN
        exp_byte = gb;
`else
        exp_byte = {gb[7:4], gb[4], gb[3:1]};
`endif
        start_cond();
        send_byte(8'h96, -1, ack);
        send_byte(8'h50, -1, ack);
        send_byte(gb, 4, ack);
        stop_cond();
`ifdef I2C_SLV_FILTER_EN
        check("glitch_ack", 32'(ack), 32'd1);
`else
        check("glitch_ack", 32'(ack), 32'd0);
`endif
        check("glitch_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("glitch_wr", 32'(wr_q[0]), 32'({8'h50, exp_byte}));
        check("glitch_ptr", 32'(reg_addr), 32'h51);
        ref_mem[8'h50] = exp_byte;
        ref_ptr = 8'h51;

        // Reset while the target holds the address ACK.
        start_cond();
        gb = 8'h96;
        for (int i = 7; i >= 0; i--) bit_out(gb[i], 1'b0, line);
        sda_m = 1'b1; wait_clks(Q); scl_m = 1'b1; wait_clks(Q);
        check("ack_before_reset", 32'(sda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_reg_addr", 32'(reg_addr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        wait_clks(4);
        reset_n = 1'b1;
        ref_ptr = 8'h00;
        wait_clks(4);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(3) != 0) begin
                a7 = DEV;
            end else begin
                a7 = 7'($urandom_range(127));
                if (a7 == DEV) a7 = a7 ^ 7'h01;
            end
            run_write({a7, 1'b0}, int'($urandom_range(4, 1)), $urandom, am, nwr);
            if (it % 2 == 1) run_read(8'($urandom), int'($urandom_range(3, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
